// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, data-phase states and the queued command record
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    typedef enum logic [1:0] {D_IDLE, D_BUSY, D_ERR} dstate_t;
    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;
endpackage

// File: rtl/ahb_lite_cmd_master_if.sv
// ahb_lite_cmd_master_if: command/response stream plus AHB-Lite master bus signals
interface ahb_lite_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
               HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahb_lite_cmd_master_cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with full/empty flags, pointers carry a wrap bit
module cmd_fifo import ahb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    cmd_t mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    always_comb begin
        wr_d = push ? wr_q + (AW+1)'(1) : wr_q;
        rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
    end
    assign empty = wr_q == rd_q;
    assign full  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign dout  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: turns a queued command stream into pipelined AHB-Lite SINGLE word transfers
module ahb_lite_cmd_master import ahb_pkg::*; #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic HCLK,
    input logic HRESETn,
    ahb_lite_cmd_master_if.master bus
);
    cmd_t push_cmd, head, issue_cmd, rp_cmd_q, rp_cmd_d;
    logic full, empty, pop, a_nonseq, a_done, err1, can_issue, issue, rsp_done;
    logic [1:0] htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [DATA_W-1:0] awdata_q, awdata_d, hwdata_q, hwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic hwrite_q, hwrite_d, dwrite_q, dwrite_d, rp_valid_q, rp_valid_d;
    logic rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
    dstate_t ds_q, ds_d;

    assign push_cmd = cmd_t'{write: bus.cmd_write, addr: {bus.cmd_addr[ADDR_W-1:2], 2'b00}, wdata: bus.cmd_wdata};

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(HCLK), .rst_n(HRESETn), .push(bus.cmd_valid && !full), .din(push_cmd),
        .pop(pop), .dout(head), .full(full), .empty(empty)
    );

    // A first ERROR cycle cancels whatever address phase is on the bus; it is parked for replay
    always_comb begin
        a_nonseq    = htrans_q == HTRANS_NONSEQ;
        a_done      = a_nonseq && bus.HREADY;
        err1        = ds_q == D_BUSY && !bus.HREADY && bus.HRESP == HRESP_ERROR;
        can_issue   = (!a_nonseq || a_done) && !err1 && !(ds_q == D_ERR && !bus.HREADY);
        issue       = can_issue && (rp_valid_q || !empty);
        issue_cmd   = rp_valid_q ? rp_cmd_q : head;
        pop         = issue && !rp_valid_q;
        htrans_d    = err1 ? HTRANS_IDLE : can_issue ? (issue ? HTRANS_NONSEQ : HTRANS_IDLE) : htrans_q;
        haddr_d     = issue ? issue_cmd.addr : haddr_q;
        hwrite_d    = issue ? issue_cmd.write : hwrite_q;
        awdata_d    = issue ? issue_cmd.wdata : awdata_q;
        rp_valid_d  = err1 ? a_nonseq : can_issue ? 1'b0 : rp_valid_q;
        rp_cmd_d    = err1 ? cmd_t'{write: hwrite_q, addr: haddr_q, wdata: awdata_q} : rp_cmd_q;
        dwrite_d    = a_done ? hwrite_q : dwrite_q;
        hwdata_d    = a_done ? (hwrite_q ? awdata_q : '0) : hwdata_q;
        ds_d        = ds_q == D_ERR ? (bus.HREADY ? D_IDLE : D_ERR) :
                      err1 ? D_ERR :
                      ((ds_q == D_BUSY && !bus.HREADY) || a_done) ? D_BUSY : D_IDLE;
        rsp_done    = ds_q != D_IDLE && bus.HREADY;
        rsp_valid_d = rsp_done;
        rsp_write_d = rsp_done ? dwrite_q : rsp_write_q;
        rsp_err_d   = rsp_done ? ds_q == D_ERR : rsp_err_q;
        rsp_rdata_d = rsp_done ? ((ds_q == D_BUSY && !dwrite_q) ? bus.HRDATA : '0) : rsp_rdata_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            awdata_q    <= '0;
            rp_valid_q  <= 1'b0;
            rp_cmd_q    <= '0;
            dwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            ds_q        <= D_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            awdata_q    <= awdata_d;
            rp_valid_q  <= rp_valid_d;
            rp_cmd_q    <= rp_cmd_d;
            dwrite_q    <= dwrite_d;
            hwdata_q    <= hwdata_d;
            ds_q        <= ds_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.HTRANS    = htrans_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HWDATA    = hwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = !empty || a_nonseq || ds_q != D_IDLE || rp_valid_q;
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb_ahb_lite_cmd_master: scenario tasks with inline checks plus an in-order response scoreboard
module tb_ahb_lite_cmd_master;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];
    exp_t m_e;

    ahb_lite_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus();
    ahb_lite_cmd_master #(.FIFO_DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (HRESETn && bus.rsp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected got write=%0b err=%0b rdata=%h exp no response", bus.rsp_write, bus.rsp_err, bus.rsp_rdata);
            end else begin
                m_e = exp_q.pop_front();
                if ({bus.rsp_write, bus.rsp_err, bus.rsp_rdata} !== {m_e.write, m_e.err, m_e.rdata}) begin
                    n_bad++;
                    $display("FAIL rsp_scoreboard got write=%0b err=%0b rdata=%h exp write=%0b err=%0b rdata=%h",
                             bus.rsp_write, bus.rsp_err, bus.rsp_rdata, m_e.write, m_e.err, m_e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic err, input logic [31:0] rd);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        exp_q.push_back('{write: w, err: err, rdata: rd});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL %s_drain got %0d pending exp 0", name, exp_q.size()); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy got %b exp 0", name, bus.busy); end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++;
        if ({bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE} !== 67'd0) begin
            n_bad++; $display("FAIL reset_bus got htrans=%b haddr=%h hwdata=%h hwrite=%b exp all 0", bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE);
        end
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_write, bus.rsp_rdata, bus.busy, bus.cmd_ready} !== {36'd0, 1'b1}) begin
            n_bad++; $display("FAIL reset_rsp got valid=%b err=%b write=%b rdata=%h busy=%b ready=%b exp 0,0,0,0,0,1",
                              bus.rsp_valid, bus.rsp_err, bus.rsp_write, bus.rsp_rdata, bus.busy, bus.cmd_ready);
        end
        n_cmp++;
        if ({bus.HSIZE, bus.HBURST} !== 6'b010_000) begin n_bad++; $display("FAIL reset_size_burst got %b exp 010000", {bus.HSIZE, bus.HBURST}); end
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        send(1'b1, 32'h0, 32'h1, 1'b0, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (bus.HTRANS !== 2'b00) begin n_bad++; $display("FAIL single_accept_htrans got %b exp 00", bus.HTRANS); end
        tick();
        n_cmp++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE} !== {2'b10, 32'h0, 1'b1}) begin
            n_bad++; $display("FAIL single_nonseq got htrans=%b haddr=%h hwrite=%b exp 10 0 1", bus.HTRANS, bus.HADDR, bus.HWRITE);
        end
        tick();
        n_cmp++;
        if ({bus.HTRANS, bus.HWDATA, bus.rsp_valid} !== {2'b00, 32'h1, 1'b0}) begin
            n_bad++; $display("FAIL single_data got htrans=%b hwdata=%h rsp_valid=%b exp 00 1 0", bus.HTRANS, bus.HWDATA, bus.rsp_valid);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h0}) begin
            n_bad++; $display("FAIL single_rsp got valid=%b err=%b rdata=%h exp 1 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        drain("single");
    endtask

    task automatic test_back_to_back();
        bus.HRDATA = 32'h0000_0007;
        send(1'b1, 32'h4, 32'h0000_00A5, 1'b0, 32'h0);
        tick();
        send(1'b0, 32'h4, 32'h0, 1'b0, 32'h7);
        tick();
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if ({bus.HTRANS, bus.HWRITE, bus.HADDR} !== {2'b10, 1'b1, 32'h4}) begin
            n_bad++; $display("FAIL b2b_first got htrans=%b hwrite=%b haddr=%h exp 10 1 4", bus.HTRANS, bus.HWRITE, bus.HADDR);
        end
        tick();
        n_cmp++;
        if ({bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HWDATA} !== {2'b10, 1'b0, 32'h4, 32'hA5}) begin
            n_bad++; $display("FAIL b2b_second got htrans=%b hwrite=%b haddr=%h hwdata=%h exp 10 0 4 a5", bus.HTRANS, bus.HWRITE, bus.HADDR, bus.HWDATA);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_write, bus.HTRANS} !== {1'b1, 1'b1, 2'b00}) begin
            n_bad++; $display("FAIL b2b_rsp1 got valid=%b write=%b htrans=%b exp 1 1 00", bus.rsp_valid, bus.rsp_write, bus.HTRANS);
        end
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h7}) begin
            n_bad++; $display("FAIL b2b_rsp2 got valid=%b write=%b rdata=%h exp 1 0 7", bus.rsp_valid, bus.rsp_write, bus.rsp_rdata);
        end
        drain("b2b");
    endtask

    task automatic test_wait_states();
        logic [31:0] hw0;
        bus.HRDATA = 32'h1234_5678;
        send(1'b0, 32'h8, 32'h0, 1'b0, 32'h1234_5678);
        tick();
        send(1'b1, 32'hF, 32'h0000_BEEF, 1'b0, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        hw0 = bus.HWDATA;
        n_cmp++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE} !== {2'b10, 32'hC, 1'b1}) begin
            n_bad++; $display("FAIL wait_addr_mask got htrans=%b haddr=%h hwrite=%b exp 10 c 1", bus.HTRANS, bus.HADDR, bus.HWRITE);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.rsp_valid} !== {2'b10, 32'hC, 1'b1, hw0, 1'b0}) begin
                n_bad++; $display("FAIL wait_hold%0d got htrans=%b haddr=%h hwrite=%b hwdata=%h rsp_valid=%b exp 10 c 1 %h 0",
                                  i, bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.rsp_valid, hw0);
            end
        end
        bus.HREADY = 1'b1;
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.HWDATA} !== {2'b10, 32'h1234_5678, 32'hBEEF}) begin
            n_bad++; $display("FAIL wait_rsp got valid=%b write=%b rdata=%h hwdata=%h exp 1 0 12345678 beef",
                              bus.rsp_valid, bus.rsp_write, bus.rsp_rdata, bus.HWDATA);
        end
        drain("wait");
    endtask

    task automatic test_fifo_full();
        bus.HREADY = 1'b0;
        bus.HRDATA = 32'h33;
        send(1'b1, 32'h10, 32'h11, 1'b0, 32'h0);
        tick();
        send(1'b1, 32'h14, 32'h22, 1'b0, 32'h0);
        tick();
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_one got %b exp 1", bus.cmd_ready); end
        send(1'b0, 32'h18, 32'h0, 1'b0, 32'h33);
        tick();
        bus.cmd_valid = 1'b0;
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_drop got %b exp 0", bus.cmd_ready); end
        tick();
        n_cmp++;
        if ({bus.cmd_ready, bus.HTRANS, bus.HADDR} !== {1'b0, 2'b10, 32'h10}) begin
            n_bad++; $display("FAIL full_hold got ready=%b htrans=%b haddr=%h exp 0 10 10", bus.cmd_ready, bus.HTRANS, bus.HADDR);
        end
        bus.HREADY = 1'b1;
        drain("full");
    endtask

    task automatic test_error();
        send(1'b1, 32'h20, 32'hA1, 1'b1, 32'h0);
        tick();
        send(1'b1, 32'h24, 32'hA2, 1'b0, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        tick();
        n_cmp++;
        if ({bus.HTRANS, bus.rsp_valid} !== {2'b00, 1'b0}) begin
            n_bad++; $display("FAIL err_cancel got htrans=%b rsp_valid=%b exp 00 0", bus.HTRANS, bus.rsp_valid);
        end
        bus.HREADY = 1'b1;
        tick();
        bus.HRESP = 1'b0;
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 32'h0}) begin
            n_bad++; $display("FAIL err_rsp got valid=%b err=%b rdata=%h exp 1 1 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        n_cmp++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE} !== {2'b10, 32'h24, 1'b1}) begin
            n_bad++; $display("FAIL err_replay got htrans=%b haddr=%h hwrite=%b exp 10 24 1", bus.HTRANS, bus.HADDR, bus.HWRITE);
        end
        tick();
        n_cmp++;
        if (bus.HWDATA !== 32'hA2) begin n_bad++; $display("FAIL err_replay_data got %h exp a2", bus.HWDATA); end
        drain("err");
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h30;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        bus.HREADY = 1'b0;
        tick();
        HRESETn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE, bus.rsp_valid, bus.busy, bus.cmd_ready} !== {69'd0, 1'b1}) begin
            n_bad++; $display("FAIL rstmid_async got htrans=%b haddr=%h hwdata=%h hwrite=%b rsp_valid=%b busy=%b ready=%b exp 0s and ready 1",
                              bus.HTRANS, bus.HADDR, bus.HWDATA, bus.HWRITE, bus.rsp_valid, bus.busy, bus.cmd_ready);
        end
        bus.HREADY = 1'b1;
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            n_bad++; $display("FAIL rstmid_release got busy=%b rsp_valid=%b exp 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.HRDATA    = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_states();
        test_fifo_full();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
